// File: rtl/dvp_frame_tx_if.sv
// Bundle of the frame-RAM read port and the DVP byte stream.
// The master side (the transmitter) reads RAM and drives the DVP pins.
interface dvp_frame_tx_if;
    logic [18:0] ram_addr;
    logic        ram_rd;
    logic [11:0] ram_data;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;

    modport master (
        output ram_addr, ram_rd, dvp_vsync, dvp_href, dvp_data,
        input  ram_data
    );

    modport slave (
        input  ram_addr, ram_rd, dvp_vsync, dvp_href, dvp_data,
        output ram_data
    );
endinterface

// File: rtl/dvp_frame_tx.sv
// DVP camera emulator: streams RGB444 pixels from frame RAM as RGB565-packed
// bytes with vsync/href framing. Every output is a flop.
module dvp_frame_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 32,
    parameter int V_LEAD   = 16,
    parameter int V_BLANK  = 64
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           en,
    dvp_frame_tx_if.master bus,
    output logic           busy,
    output logic           frame_done
);

    typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, VBLANK} state_t;

    localparam int          LINE_BYTES = 2 * H_ACTIVE;
    localparam logic [11:0] LEAD_LAST  = 12'(V_LEAD - 1);
    localparam logic [11:0] LINE_LAST  = 12'(LINE_BYTES - 1);
    localparam logic [11:0] HB_LAST    = 12'(H_BLANK - 1);
    localparam logic [11:0] VB_LAST    = 12'(V_BLANK - 1);
    localparam logic [9:0]  LAST_LINE  = 10'(V_ACTIVE - 1);

    state_t      state, state_next;
    logic [11:0] cnt, cnt_next;
    logic [9:0]  line_cnt, line_cnt_next;
    logic [7:0]  pix_lo, pix_lo_next;
    logic [7:0]  data_next;
    logic        rd_next;
    logic        more_lines;
    int          ahead;

    assign more_lines = (line_cnt != LAST_LINE);

    always_comb begin
        state_next    = state;
        cnt_next      = cnt + 12'd1;
        line_cnt_next = line_cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (en) state_next = LEAD;
            end
            LEAD: begin
                if (cnt == LEAD_LAST) begin
                    state_next    = LINE;
                    cnt_next      = '0;
                    line_cnt_next = '0;
                end
            end
            LINE: begin
                if (cnt == LINE_LAST) begin
                    state_next = HBLANK;
                    cnt_next   = '0;
                end
            end
            HBLANK: begin
                if (cnt == HB_LAST) begin
                    cnt_next = '0;
                    if (more_lines) begin
                        state_next    = LINE;
                        line_cnt_next = line_cnt + 10'd1;
                    end else begin
                        state_next = VBLANK;
                    end
                end
            end
            VBLANK: begin
                if (cnt == VB_LAST) begin
                    cnt_next   = '0;
                    state_next = en ? LEAD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The read strobe leaves its flop two cycles before the hi byte that
        // needs it, so look three cycles ahead of the current state.
        ahead = -1;
        case (state)
            LEAD:   ahead = int'(cnt) + 3 - V_LEAD;
            LINE: begin
                if (int'(cnt) + 3 < LINE_BYTES) ahead = int'(cnt) + 3;
                else if (more_lines) ahead = int'(cnt) + 3 - LINE_BYTES - H_BLANK;
            end
            HBLANK: if (more_lines) ahead = int'(cnt) + 3 - H_BLANK;
            default: ahead = -1;
        endcase
        rd_next = (ahead >= 0) && (ahead < LINE_BYTES) && (ahead % 2 == 0);

        data_next   = 8'h00;
        pix_lo_next = pix_lo;
        if (state_next == LINE) begin
            if (!cnt_next[0]) begin
                data_next   = {bus.ram_data[11:8], 1'b0, bus.ram_data[7:5]};
                pix_lo_next = {bus.ram_data[4], 2'b00, bus.ram_data[3:0], 1'b0};
            end else begin
                data_next = pix_lo;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            line_cnt      <= '0;
            pix_lo        <= '0;
            bus.ram_addr  <= '0;
            bus.ram_rd    <= 1'b0;
            bus.dvp_vsync <= 1'b0;
            bus.dvp_href  <= 1'b0;
            bus.dvp_data  <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            line_cnt      <= line_cnt_next;
            pix_lo        <= pix_lo_next;
            bus.ram_rd    <= rd_next;
            bus.dvp_vsync <= state_next inside {LEAD, LINE, HBLANK};
            bus.dvp_href  <= (state_next == LINE);
            bus.dvp_data  <= data_next;
            busy          <= (state_next != IDLE);
            frame_done    <= (state_next == VBLANK) && (state != VBLANK);
            if (state_next == LEAD && state != LEAD)
                bus.ram_addr <= '0;
            else if (bus.ram_rd)
                bus.ram_addr <= bus.ram_addr + 19'd1;
        end
    end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Randomized bench for dvp_frame_tx on a small frame, checked cycle by cycle
// against a frame-timeline model computed from line/frame arithmetic.
module tb_dvp_frame_tx;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int HB = 3;
    localparam int VL = 4;
    localparam int VB = 5;
    localparam int LP = 2 * H + HB;
    localparam int F  = VL + V * LP + VB;
    localparam int N  = H * V;

    logic pclk = 1'b0;
    logic rst;
    logic en;
    logic busy;
    logic frame_done;

    dvp_frame_tx_if bus();

    dvp_frame_tx #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_LEAD(VL), .V_BLANK(VB)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .en(en),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    logic [11:0] mem [N];
    int checks;
    int fails;
    int expAddr;
    int readCount;
    logic [7:0] prevByte;

    // Frame RAM with one cycle of read latency.
    always_ff @(posedge pclk) begin
        if (bus.ram_rd) bus.ram_data <= mem[int'(bus.ram_addr) % N];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] hiByte(input logic [11:0] w);
        return {w[11:8], 1'b0, w[7:5]};
    endfunction

    function automatic logic [7:0] loByte(input logic [11:0] w);
        return {w[4], 2'b00, w[3:0], 1'b0};
    endfunction

    // Expected {busy, frame_done, vsync, href, data} for cycle n after en is sampled.
    task automatic modelAt(input int n, input int nframes, output logic [11:0] exp,
                           output int pix, output bit isLo);
        int off, l, p;
        exp  = '0;
        pix  = 0;
        isLo = 1'b0;
        if (n >= 1 && n <= nframes * F) begin
            off = (n - 1) % F;
            if (off < VL) begin
                exp = {4'b1010, 8'h00};
            end else if (off < VL + V * LP) begin
                l = (off - VL) / LP;
                p = (off - VL) % LP;
                if (p < 2 * H) begin
                    pix  = l * H + p / 2;
                    isLo = (p % 2 == 1);
                    exp  = {4'b1011, isLo ? loByte(mem[pix]) : hiByte(mem[pix])};
                end else begin
                    exp = {4'b1010, 8'h00};
                end
            end else begin
                exp = {1'b1, off == VL + V * LP, 2'b00, 8'h00};
            end
        end
    endtask

    task automatic sampleCycle(input int n, input int nframes);
        logic [11:0] exp;
        int pix;
        bit isLo;
        modelAt(n, nframes, exp, pix, isLo);
        checkOutput($sformatf("cycle%0d", n),
                    32'({busy, frame_done, bus.dvp_vsync, bus.dvp_href, bus.dvp_data}),
                    32'(exp));
        if (isLo)
            checkOutput("decode", 32'({prevByte[7:4], prevByte[2:0], bus.dvp_data[7], bus.dvp_data[4:1]}),
                        32'(mem[pix]));
        prevByte = bus.dvp_data;
        if (bus.ram_rd) begin
            checkOutput("ram_addr", 32'(bus.ram_addr), 32'(expAddr));
            expAddr = (expAddr + 1) % N;
            readCount++;
        end
    endtask

    task automatic applyStimulus(input int nframes, input int enLen);
        readCount = 0;
        @(negedge pclk);
        en = 1'b1;
        for (int n = 1; n <= nframes * F + 4; n++) begin
            @(negedge pclk);
            if (n == enLen) en = 1'b0;
            sampleCycle(n, nframes);
        end
        checkOutput("read_count", 32'(readCount), 32'(nframes * N));
    endtask

    task automatic randomizeMem();
        for (int i = 0; i < N; i++) mem[i] = 12'($urandom);
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        expAddr = 0;
        prevByte = 8'h00;
        rst = 1'b1;
        en  = 1'b0;
        randomizeMem();
        repeat (3) @(negedge pclk);
        checkOutput("reset_state",
                    {busy, frame_done, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, bus.ram_rd, bus.ram_addr},
                    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge pclk);
        checkOutput("idle_state",
                    {busy, frame_done, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, bus.ram_rd, bus.ram_addr},
                    32'd0);

        // Single frame with a one-cycle en pulse and the packing corner words.
        mem[0] = 12'hABC;
        mem[1] = 12'hFFF;
        mem[2] = 12'h000;
        applyStimulus(1, 1);

        // Three back-to-back frames; en drops mid-line of the third.
        randomizeMem();
        applyStimulus(3, 2 * F + VL + 3);

        // en dropped mid-line of the first frame.
        randomizeMem();
        applyStimulus(1, VL + LP + 3);

        // Reset in the middle of a line, then a fresh frame.
        randomizeMem();
        @(negedge pclk);
        en = 1'b1;
        for (int n = 1; n <= VL + 3; n++) begin
            @(negedge pclk);
            if (n == 1) en = 1'b0;
            sampleCycle(n, 1);
        end
        rst = 1'b1;
        @(negedge pclk);
        checkOutput("rst_mid_line",
                    32'({busy, frame_done, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, bus.ram_rd}),
                    32'd0);
        rst = 1'b0;
        expAddr = 0;
        repeat (3) @(negedge pclk);
        checkOutput("idle_after_rst", 32'({busy, bus.dvp_vsync, bus.dvp_href}), 32'd0);
        applyStimulus(1, 1);

        // Random images, frame counts and en drop points.
        repeat (4) begin
            int nf;
            int enLen;
            randomizeMem();
            nf    = int'($urandom_range(1, 2));
            enLen = (nf - 1) * F + int'($urandom_range(1, F));
            applyStimulus(nf, enLen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dvp_frame_tx.md
# dvp_frame_tx

Transmit side of the camera DVP link. Reads RGB444 pixels from frame RAM and emits them as a DVP byte stream (vsync/href/8-bit data, two bytes per pixel, RGB565 packing) timed so the capture path reconstructs identical 12-bit pixels. It serves as the camera emulator for loopback testing and as the source for a second board's camera port.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- H_BLANK, 32, href-low cycles after each line, ≥1
- V_LEAD, 16, cycles from vsync rise to the first href rise, ≥3
- V_BLANK, 64, vsync-low cycles after each frame, ≥3
- pclk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  level; while high, frames are sent back-to-back
- ram_addr  out  19  frame RAM read address
- ram_rd  out  1  read strobe
- ram_data  in  12  {R[3:0],G[3:0],B[3:0]}; valid in the cycle after ram_rd
- dvp_vsync  out  1  high for the whole frame, including lead, lines and line blanks
- dvp_href  out  1  high during active bytes of a line
- dvp_data  out  8  byte stream; 0 whenever dvp_href is low
- busy  out  1  high from frame start through the end of V_BLANK
- frame_done  out  1  one-cycle pulse at the end of each frame

## Operation
- FSM states: IDLE → LEAD → LINE → HBLANK → (LINE | VBLANK) → (LEAD | IDLE).
- IDLE: all outputs low. Sampling en=1 moves to LEAD on the next cycle and sets busy.
- LEAD: dvp_vsync=1 and dvp_href=0 for V_LEAD cycles. The first-pixel RAM read is issued in time for byte 0.
- LINE: dvp_href=1 for exactly 2*H_ACTIVE consecutive cycles. Byte 2k = hi(pixel k), byte 2k+1 = lo(pixel k).
- Packing for pixel {R,G,B}: hi = {R[3:0], 1'b0, G[3:1]}; lo = {G[0], 2'b00, B[3:0], 1'b0}.
- HBLANK: href=0, vsync=1 for H_BLANK cycles. Next state is LINE if lines remain, otherwise VBLANK.
- VBLANK: vsync=0 for V_BLANK cycles. frame_done pulses in the first VBLANK cycle.
- At the end of VBLANK: if en=1, go to LEAD (new frame); else go to IDLE and clear busy.
- en is sampled only in IDLE and at the end of VBLANK. Dropping en mid-frame completes the current frame, including VBLANK.
- Addressing: ram_addr = line*H_ACTIVE + k. It is 0 at every frame start and last reads H_ACTIVE*V_ACTIVE-1. There is no wrap within a frame.
- Exactly one ram_rd per pixel, i.e. H_ACTIVE*V_ACTIVE per frame.
- Counters: a byte/cycle counter (12 bits) and a line counter (10 bits), compared against the parameters. The address is a 19-bit incrementer.
- rst at any point: return to IDLE in the next cycle. All outputs are 0 and counters are cleared; no partial frame resumes.

## Timing
- All outputs are registered. Reset value of every output is 0.
- en=1 sampled in IDLE at cycle t: dvp_vsync rises at t+1, and the first dvp_href rises at t+1+V_LEAD.
- Line period = 2*H_ACTIVE + H_BLANK cycles.
- Frame period = V_LEAD + V_ACTIVE*(2*H_ACTIVE+H_BLANK) + V_BLANK cycles. The vsync-high portion ends immediately after the last HBLANK.
- RAM read latency is fixed at 1 cycle. There is no backpressure: ram_data must be valid as specified.
- dvp_data changes only on pclk rising edges. The receiver samples on the same edge in the next cycle.

## Test plan
- Single frame (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, V_LEAD=4, V_BLANK=5), RAM[i]=i, en pulsed 1 cycle:
  - vsync rises 1 cycle after en and stays high 4+2*(8+3)=26 cycles.
  - href is high in two 8-cycle runs; ram_addr reads 0..7.
  - frame_done pulses once, busy falls after 5 VBLANK cycles.
- Packing: RAM word 12'hABC → bytes 0xA5, 0x98. 12'hFFF → 0xF7, 0x9E. 12'h000 → 0x00, 0x00. Capture-path decode returns the original word.
- Continuous mode, en held high for 3 frames: three frame_done pulses, equal frame periods, LEAD restarts directly after VBLANK, ram_addr resets to 0 each frame.
- en dropped mid-line of frame 1: frame completes with all V_ACTIVE lines, then IDLE, busy=0, no further vsync.
- rst asserted during LINE: next cycle vsync=href=data=0 and busy=0. A subsequent en starts a fresh frame at address 0.
- Default parameters, loopback into the capture block with a random RAM image: 307200 pixels captured, all match, exactly 640 pixels per href run.
